// File: rtl/linebuf_sram_ctrl_pkg.sv
// Shared definitions for the conv-layer line-buffer SRAM controller.
// Geometry constants, FSM state encoding, address/row types and the
// row-to-bank mapping used by every file of the block.
package linebuf_pkg;

  localparam int KER_SIZE  = 3;                               // kernel height, read banks
  localparam int PAD       = 1;                               // top/bottom zero rows
  localparam int MAX_X_DIM = 64;                              // max row length, SRAM depth
  localparam int MAX_Y_DIM = 64;                              // max image height
  localparam int AW        = $clog2(MAX_X_DIM);               // column address width
  localparam int YW        = $clog2(MAX_Y_DIM + KER_SIZE + 1); // row counter width
  localparam int SW        = 3;                               // stride field width
  localparam int NB        = KER_SIZE + 1;                    // banks in the ring
  localparam int BW        = $clog2(NB);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  typedef logic [AW-1:0]        col_t;
  typedef logic signed [YW+1:0] row_t;  // signed so padding rows go negative
  typedef logic [BW-1:0]        bank_t;

  // Bank holding a given image row. Only called for rows >= 0.
  function automatic bank_t bank_of(input row_t row);
    row_t m;
    m = row % row_t'(NB);
    return bank_t'(m);
  endfunction

endpackage

// File: rtl/linebuf_sram_ctrl_if.sv
// Pixel/window handshake and SRAM control bundle.
//   in_valid/in_ready   : input pixel stream
//   out_ready           : downstream accepts a window column
//   addr                : shared SRAM column address
//   write_en / read_en  : per-bank enables
//   win_valid           : window column issued, SRAM data valid next cycle
//   row_pad_mask        : kernel rows that are padding
//   win_last_col        : last column of a window row
// master = controller side, slave = pixel source / window consumer side.
interface linebuf_sram_ctrl_if;
  import linebuf_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                out_ready;
  col_t                addr;
  logic [NB-1:0]       write_en;
  logic [NB-1:0]       read_en;
  logic                win_valid;
  logic [KER_SIZE-1:0] row_pad_mask;
  logic                win_last_col;

  modport master (
    input  in_valid, out_ready,
    output in_ready, addr, write_en, read_en, win_valid, row_pad_mask, win_last_col
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, addr, write_en, read_en, win_valid, row_pad_mask, win_last_col
  );

endinterface

// File: rtl/linebuf_sram_ctrl_row_sched.sv
// Row scheduler for the line buffer: tracks the row being written (wrow,
// virtual beyond the image during flush) and the next output row (orow).
// Derives when a window is due, which kernel rows are padding, which banks
// must be read, and whether the current window is the last of the frame.
//   clear    : restart counters for a new frame
//   row_end  : a (real or virtual) write row completes this cycle
//   y_dim, stride, out_h : latched frame geometry
//   wrow, wbank          : current write row and its bank
//   due, last_win, all_done, pad_mask, rd_sel : window schedule outputs
module linebuf_row_sched
  import linebuf_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                row_end,
  input  logic [YW-1:0]       y_dim,
  input  logic [SW-1:0]       stride,
  input  logic [YW-1:0]       out_h,
  output logic [YW-1:0]       wrow,
  output bank_t               wbank,
  output logic                due,
  output logic                last_win,
  output logic                all_done,
  output logic [KER_SIZE-1:0] pad_mask,
  output logic [NB-1:0]       rd_sel
);

  logic [YW-1:0] orow;
  row_t          base;     // image row of kernel row 0 for window orow
  row_t          t_o;      // write row during which window orow is issued
  row_t          img_row;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    pad_mask = '0;
    rd_sel   = '0;
    img_row  = '0;
    base     = row_t'(orow) * row_t'(stride) - row_t'(PAD);
    t_o      = base + row_t'(KER_SIZE);
    all_done = (orow >= out_h);
    due      = !all_done && (row_t'(wrow) == t_o);
    last_win = (orow == out_h - YW'(1));
    wbank    = bank_of(row_t'(wrow));
    for (int k = 0; k < KER_SIZE; k++) begin
      img_row = base + row_t'(k);
      if (img_row < 0 || img_row >= row_t'(y_dim)) begin
        pad_mask[k] = 1'b1;
      end else begin
        rd_sel[bank_of(img_row)] = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrow <= '0;
      orow <= '0;
    end else if (clear) begin
      wrow <= '0;
      orow <= '0;
    end else if (row_end) begin
      wrow <= wrow + YW'(1);
      if (due) orow <= orow + YW'(1);
    end
  end

endmodule

// File: rtl/linebuf_sram_ctrl.sv
// Line-buffer SRAM address/enable controller. Streams pixels into one bank
// of a KER_SIZE+1 bank ring while issuing kernel-row window reads from the
// others, then flushes the bottom-padding windows without input.
//   clk, rstn            : clock, async active-low reset
//   start                : frame start, honoured in IDLE only
//   cfg_x_dim/y_dim/stride : frame geometry, latched on start
//   bus (master)         : pixel/window handshake and SRAM enables
//   frame_done           : one cycle after the last window column
//   busy                 : frame in progress
module linebuf_sram_ctrl
  import linebuf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [AW:0]          cfg_x_dim,
  input  logic [YW-1:0]        cfg_y_dim,
  input  logic [SW-1:0]        cfg_stride,
  linebuf_sram_ctrl_if.master  bus,
  output logic                 frame_done,
  output logic                 busy
);

  state_t        state;
  col_t          col;
  logic [AW:0]   x_dim;
  logic [YW-1:0] y_dim;
  logic [YW-1:0] out_h;
  logic [SW-1:0] stride;

  logic [YW:0]   oh_num;
  logic [YW-1:0] oh_calc;

  logic [YW-1:0]       wrow;
  bank_t               wbank;
  logic                due, last_win, all_done;
  logic [KER_SIZE-1:0] pad_mask;
  logic [NB-1:0]       rd_sel;

  logic in_ready, fire, win_valid, advance, row_end, win_done, col_last;

  // Output rows of the padded image for the requested stride.
  assign oh_num  = {1'b0, cfg_y_dim} + (YW+1)'(2 * PAD) - (YW+1)'(KER_SIZE);
  assign oh_calc = YW'(oh_num / (YW+1)'(cfg_stride)) + YW'(1);

  assign col_last = ({1'b0, col} == x_dim - (AW+1)'(1));

  linebuf_row_sched u_sched (
    .clk      (clk),
    .rstn     (rstn),
    .clear    ((state == IDLE) && start),
    .row_end  (row_end),
    .y_dim    (y_dim),
    .stride   (stride),
    .out_h    (out_h),
    .wrow     (wrow),
    .wbank    (wbank),
    .due      (due),
    .last_win (last_win),
    .all_done (all_done),
    .pad_mask (pad_mask),
    .rd_sel   (rd_sel)
  );

  always_comb begin
    in_ready  = 1'b0;
    fire      = 1'b0;
    win_valid = 1'b0;
    advance   = 1'b0;
    unique case (state)
      STREAM: begin
        // A due window column can only go out together with its pixel write.
        in_ready  = !due || bus.out_ready;
        fire      = bus.in_valid && in_ready;
        win_valid = fire && due;
        advance   = fire;
      end
      FLUSH: begin
        win_valid = due;
        advance   = !due || bus.out_ready;
      end
      default: ;
    endcase
    // Flush rows with no window are skipped in one cycle with col held at 0.
    row_end  = advance && (col_last || (state == FLUSH && !due));
    win_done = row_end && due && last_win;

    bus.write_en = '0;
    if (fire) bus.write_en[wbank] = 1'b1;
    bus.read_en      = win_valid ? rd_sel : '0;
    bus.row_pad_mask = win_valid ? pad_mask : '0;
    bus.win_last_col = win_valid && col_last;
    bus.win_valid    = win_valid;
    bus.in_ready     = in_ready;
  end

  assign bus.addr   = col;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      col    <= '0;
      x_dim  <= '0;
      y_dim  <= '0;
      stride <= '0;
      out_h  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            x_dim  <= cfg_x_dim;
            y_dim  <= cfg_y_dim;
            stride <= cfg_stride;
            out_h  <= oh_calc;
            col    <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (advance) col <= col_last ? '0 : col + col_t'(1);
          // If the last window already went out while streaming, no flush is needed.
          if (row_end && wrow == y_dim - YW'(1)) begin
            state <= (all_done || win_done) ? DONE : FLUSH;
          end
        end
        FLUSH: begin
          if (advance && due) col <= col_last ? '0 : col + col_t'(1);
          if (win_done) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linebuf_sram_ctrl.sv
// Self-checking bench for linebuf_sram_ctrl. A frame-level reference model
// lists every expected pixel write and window column in order; each DUT
// event is popped and compared as it happens.
module tb_linebuf_sram_ctrl;
  import linebuf_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_x_dim = '0;
  logic [YW-1:0] cfg_y_dim = '0;
  logic [SW-1:0] cfg_stride = '0;
  logic          frame_done;
  logic          busy;

  linebuf_sram_ctrl_if bus();

  linebuf_sram_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_x_dim  (cfg_x_dim),
    .cfg_y_dim  (cfg_y_dim),
    .cfg_stride (cfg_stride),
    .bus        (bus.master),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { int row; int bank; int addr; } wr_ev_t;
  typedef struct { int o; int addr; int mask; int rd; int last; int t; } win_ev_t;

  wr_ev_t  wr_q[$];
  win_ev_t win_q[$];
  int cur_y, cur_wrow, done_pulses, writes_seen;

  // Expected events and, for an always-ready run, the cycle at which
  // frame_done appears (first streaming cycle = 1).
  task automatic build_model(input int x, input int y, input int s, output int exp_cyc);
    int out_h, t_last, m, rd, r;
    wr_q.delete();
    win_q.delete();
    out_h = (y + 2 * PAD - KER_SIZE) / s + 1;
    for (int w = 0; w < y; w++)
      for (int c = 0; c < x; c++)
        wr_q.push_back('{w, w % NB, c});
    for (int o = 0; o < out_h; o++) begin
      m  = 0;
      rd = 0;
      for (int k = 0; k < KER_SIZE; k++) begin
        r = o * s - PAD + k;
        if (r < 0 || r >= y) m |= (1 << k);
        else rd |= (1 << (r % NB));
      end
      for (int c = 0; c < x; c++)
        win_q.push_back('{o, c, m, rd, (c == x - 1) ? 1 : 0, o * s - PAD + KER_SIZE});
    end
    t_last  = (out_h - 1) * s - PAD + KER_SIZE;
    exp_cyc = x * y + 1;
    for (int v = y; v <= t_last; v++)
      exp_cyc += (v >= KER_SIZE - PAD && (v - (KER_SIZE - PAD)) % s == 0) ? x : 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},   bus.in_ready,     0);
    check({tag, "_win_valid"},  bus.win_valid,    0);
    check({tag, "_write_en"},   bus.write_en,     0);
    check({tag, "_read_en"},    bus.read_en,      0);
    check({tag, "_pad_mask"},   bus.row_pad_mask, 0);
    check({tag, "_frame_done"}, frame_done,       0);
    check({tag, "_busy"},       busy,             0);
    check({tag, "_addr"},       bus.addr,         0);
  endtask

  // Per-cycle event checker, called at the falling edge.
  task automatic monitor();
    bit      wr;
    wr_ev_t  we;
    win_ev_t ww;
    wr = (bus.write_en != 0);
    check("rd_wr_overlap", bus.read_en & bus.write_en, 0);
    if (wr) begin
      check("wr_handshake", {bus.in_valid, bus.in_ready}, 2'b11);
      if (wr_q.size() == 0) check("wr_extra", wr, 0);
      else begin
        we = wr_q.pop_front();
        check("wr_bank", bus.write_en, 1 << we.bank);
        check("wr_addr", bus.addr, we.addr);
        cur_wrow = we.row;
        writes_seen++;
      end
    end
    if (!bus.win_valid) begin
      check("idle_read_en", bus.read_en, 0);
      check("idle_last_col", bus.win_last_col, 0);
    end else if (bus.out_ready) begin
      if (win_q.size() == 0) check("win_extra", bus.win_valid, 0);
      else begin
        ww = win_q.pop_front();
        check("win_addr", bus.addr, ww.addr);
        check("win_mask", bus.row_pad_mask, ww.mask);
        check("win_read_en", bus.read_en, ww.rd);
        check("win_last_col", bus.win_last_col, ww.last);
        if (ww.t < cur_y) begin
          check("win_needs_write", wr, 1);
          if (wr) check("win_row", cur_wrow, ww.t);
        end else begin
          check("win_flush_nowrite", wr, 0);
        end
      end
    end
    if (frame_done) done_pulses++;
  endtask

  task automatic run_frame(input int x, input int y, input int s, input bit rnd,
                           input int bp_at, input int abort_at, input bit poke_start);
    int exp_cyc, n, bp_cnt, pulses0;
    bit done, stall, aborted;
    build_model(x, y, s, exp_cyc);
    if (bp_at >= 0) exp_cyc += 3;
    cur_y       = y;
    writes_seen = 0;
    pulses0     = done_pulses;
    bp_cnt      = 0;
    done        = 0;
    aborted     = 0;
    n           = 0;

    @(posedge clk); #1;
    start         = 1'b1;
    cfg_x_dim     = (AW+1)'(x);
    cfg_y_dim     = YW'(y);
    cfg_stride    = SW'(s);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk); monitor();
    @(posedge clk); #1;
    start = 1'b0;

    while (!done && n < 20000) begin
      n++;
      // Mid-frame config changes must have no effect.
      cfg_x_dim  = (AW+1)'($urandom_range(1, MAX_X_DIM));
      cfg_y_dim  = YW'($urandom_range(1, MAX_Y_DIM));
      cfg_stride = SW'($urandom_range(1, 7));
      start      = (poke_start && n == 5);
      if (rnd) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
      end
      stall = 0;
      if (bp_at >= 0 && writes_seen == bp_at && bp_cnt < 3) begin
        bus.out_ready = 1'b0;
        bp_cnt++;
        stall = 1;
      end
      if (abort_at > 0 && n == abort_at) begin
        #2;
        check("pre_abort_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rstn    = 1'b1;
        aborted = 1;
        break;
      end
      @(negedge clk);
      if (start) check("poke_busy", busy, 1);
      if (stall) begin
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_no_write", bus.write_en, 0);
        check("bp_win_valid", bus.win_valid, 0);
        check("bp_addr", bus.addr, bp_at % x);
      end
      monitor();
      if (frame_done) done = 1;
      @(posedge clk); #1;
    end
    start = 1'b0;

    if (!aborted) begin
      check("frame_finished", done, 1);
      check("writes_left", wr_q.size(), 0);
      check("windows_left", win_q.size(), 0);
      check("frame_count", done_pulses - pulses0, 1);
      if (!rnd) check("frame_cycles", n, exp_cyc);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("done_is_pulse", frame_done, 0);
      check("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    done_pulses   = 0;
    cur_wrow      = 0;
    #12;
    check_idle_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    run_frame(4, 4, 1, 0, -1, 0, 0);   // basic stride-1 frame
    run_frame(4, 5, 2, 0, -1, 0, 0);   // stride 2 with a skipped flush row
    run_frame(4, 4, 1, 0, 9, 0, 0);    // backpressure mid window row
    run_frame(5, 8, 1, 0, -1, 0, 0);   // bank ring wraps twice
    run_frame(4, 4, 1, 0, -1, 19, 0);  // reset during flush
    run_frame(4, 4, 1, 0, -1, 0, 0);   // clean frame after reset
    run_frame(3, 6, 1, 0, -1, 0, 1);   // start while busy is ignored
    run_frame(64, 3, 3, 0, -1, 0, 0);  // full-width rows
    run_frame(1, 1, 1, 0, -1, 0, 0);   // minimum geometry
    for (int i = 0; i < 20; i++) begin
      run_frame($urandom_range(1, 16), $urandom_range(1, 20), $urandom_range(1, 4),
                1, -1, 0, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linebuf_sram_ctrl.md
Name: linebuf_sram_ctrl

Overview:
Parametrised address and enable controller for the conv-layer line buffer. It manages KER_SIZE+1 single-port SRAM row banks as a ring. It streams input pixels into one bank while issuing kernel-row window reads from the other banks. It generalises the fixed-geometry controller with:
- runtime image dimensions and stride;
- top and bottom padding derived per window;
- a bottom-padding FLUSH phase that runs without input;
- valid/ready backpressure on both sides.

Parameters:
KER_SIZE, 3, kernel height; number of read banks (total banks NB = KER_SIZE+1).
PAD, 1, top/bottom zero rows; legal range 0..KER_SIZE-1.
MAX_X_DIM, 64, maximum row length; SRAM depth.
MAX_Y_DIM, 64, maximum image height.
AW, 6, address width; must satisfy 2^AW >= MAX_X_DIM.
YW, 7, row counter width; must hold MAX_Y_DIM+KER_SIZE.
SW, 3, stride field width.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  frame start pulse; sampled in IDLE only
cfg_x_dim  in  AW+1  row length, 1..MAX_X_DIM; latched on start
cfg_y_dim  in  YW  image height, KER_SIZE-2*PAD..MAX_Y_DIM; latched on start
cfg_stride  in  SW  vertical stride, >=1; latched on start
in_valid  in  1  input pixel valid
in_ready  out  1  controller accepts the pixel this cycle
out_ready  in  1  downstream accepts the window column
addr  out  AW  shared SRAM address (column)
write_en  out  KER_SIZE+1  one-hot bank write enable
read_en  out  KER_SIZE+1  bank read enables
win_valid  out  1  window column issued this cycle; SRAM data valid next cycle
row_pad_mask  out  KER_SIZE  bit k=1: kernel row k is padding, output zero
win_last_col  out  1  win_valid on the last column of a window row
frame_done  out  1  one-cycle pulse after the last window column
busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE and all counters 0; in_ready, win_valid, write_en, read_en, row_pad_mask, frame_done, busy are all 0; addr=0.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE -> STREAM on start: latch cfg; compute out_h = (y_dim + 2*PAD - KER_SIZE)/stride + 1.
  - STREAM -> FLUSH when input row y_dim-1 completes.
  - FLUSH -> DONE when the window for output row out_h-1 completes.
  - DONE -> IDLE after 1 cycle; frame_done=1 in DONE.
- Counters: col (0..x_dim-1), wrow (image row being written), orow (next output row o).
- Window schedule:
  - Window o covers image rows o*stride-PAD+k, for k=0..KER_SIZE-1.
  - Window o is due during virtual write row t(o) = o*stride-PAD+KER_SIZE.
- STREAM, per cycle:
  - due = (wrow == t(orow)); in_ready = !due || out_ready; fire = in_valid && in_ready.
  - On fire: write_en[wrow mod NB]=1 and addr=col.
  - If due, also win_valid=1 on that cycle.
  - When !fire: write_en=0, read_en=0, win_valid=0, and no counter moves.
- Read enables: read_en[b]=1 for each non-pad kernel row whose bank b = (image row) mod NB, gated by win_valid. read_en never overlaps write_en.
- row_pad_mask[k] = (image row < 0) || (image row >= y_dim), evaluated for orow.
- Row end: on the cycle with col == x_dim-1 that advances:
  - col wraps to 0 and wrow increments;
  - if due, orow increments; win_last_col=1.
- Rows with no due window, i.e. stride>1 skip rows, are still written.
- FLUSH:
  - in_ready=0, write_en=0; wrow continues as a virtual row counter.
  - A virtual row with no due window is skipped in 1 cycle, with nothing issued.
  - Otherwise addr=col and win_valid=1; advance on out_ready.
- Safety: bank overwrite is safe because the bank written for row w held row w-NB, which no pending window needs.
- Width rules:
  - image row = o*stride-PAD+k is computed signed in YW+2 bits.
  - t(o) is compared unsigned after the frame offset; no wrap within MAX_Y_DIM.
- start outside IDLE is ignored. cfg changes mid-frame have no effect.
- Asynchronous reset mid-frame returns every output to its reset value immediately; SRAM contents are don't-care.
- Windows never start before KER_SIZE-PAD rows are stored. The first window is due at wrow = KER_SIZE-PAD.

Decomposition:
- Package linebuf_pkg holds:
  - the state enum (IDLE, STREAM, FLUSH, DONE);
  - the typedefs col_t [AW-1:0] and row_t signed [YW+1:0];
  - the function bank_of(row) = row mod NB;
  - the constant NB.
- One sub-module, linebuf_row_sched: holds orow/wrow, computes t(o), due and row_pad_mask and read bank selects, and detects the last window. The top level holds the FSM, col counter, handshake and enables.

Test Plan:
- K=3, PAD=1, stride=1, x=4, y=4, out_ready=1:
  - window 0 at wrow 2 with mask 001; window 1 at wrow 3 with mask 000;
  - FLUSH passes 2 (mask 000) and 3 (mask 100), 4 cycles each;
  - frame_done 1 cycle after the last column; 16 writes and 16 win_valid total.
- Stride=2, y=5, out_h=3:
  - windows at wrow 2 and 4;
  - FLUSH skips virtual row 5 in 1 cycle and issues window 2 at virtual row 6 with mask 100.
- Backpressure: out_ready=0 for 3 cycles mid-window-row -> in_ready=0, addr/col held, no write_en; resumes with the same addr.
- Bank ring: y=8, PAD=0, stride=1 -> write bank sequence 0,1,2,3,0,1,2,3; read_en never equals write_en in any cycle.
- Reset asserted mid-FLUSH -> all outputs 0 immediately; a new start runs a complete correct frame.
- start pulsed while busy=1 -> ignored, and frame count is unchanged.
